game_state_ctrl: RTL and testbench



---
 rtl/game_pkg.sv | 21 ++
 rtl/frame_timer.sv | 29 ++
 rtl/game_state_ctrl.sv | 127 ++++++++++++
 tb/tb_game_state_ctrl.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and widths for the Digger game flow: screen codes seen by the
// pixel mux and screen generators, plus lives/gold counter widths.
package game_pkg;

    localparam int GOLD_W  = 8;
    localparam int LIVES_W = 3;

    typedef enum logic [2:0] {
        BLANK     = 3'd0,
        START     = 3'd1,
        PLAY      = 3'd2,
        WIN       = 3'd3,
        GAME_OVER = 3'd4,
        DEATH     = 3'd5
    } game_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/frame_timer.sv
// Counts video frames and flags the frame on which the programmed terminal
// count is reached; the count restarts from zero on that frame or on clear.
module frame_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             clear,
    input  logic             startOfFrame,
    input  logic [CNT_W-1:0] terminal,
    output logic             done
);

    logic [CNT_W-1:0] count_reg;

    // done is combinational so the owner can leave its state on this very edge
    assign done = startOfFrame && (count_reg == terminal);

    always_ff @(posedge clk) begin
        if (!resetN) begin
            count_reg <= '0;
        end else if (clear || done) begin
            count_reg <= '0;
        end else if (startOfFrame) begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/game_state_ctrl.sv
// Digger game flow controller: selects the screen, tracks lives and gold, and
// issues new_game / respawn pulses to the player, alien and gold controllers.
module game_state_ctrl
    import game_pkg::*;
#(
    parameter int LIVES_INIT   = 3,
    parameter int GOLD_TOTAL   = 8,
    parameter int DEATH_FRAMES = 60,
    parameter int END_FRAMES   = 180
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               start_key,
    input  logic               player_hit,
    input  logic               gold_collected,
    output logic [2:0]         game_state,
    output logic [LIVES_W-1:0] lives,
    output logic [GOLD_W-1:0]  gold_left,
    output logic               new_game,
    output logic               respawn
);

    localparam int CNT_W = $clog2(max_int(DEATH_FRAMES, END_FRAMES) + 1);

    game_state_t        state_reg, state_next;
    logic [LIVES_W-1:0] lives_reg, lives_next;
    logic [GOLD_W-1:0]  gold_reg, gold_next;
    logic               new_game_reg, new_game_next;
    logic               respawn_reg, respawn_next;
    logic               start_key_d_reg;
    logic               key_rise;

    logic               timer_clear;
    logic               timer_done;
    logic [CNT_W-1:0]   timer_terminal;

    assign key_rise = start_key && !start_key_d_reg;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_reg       <= BLANK;
            lives_reg       <= LIVES_W'(LIVES_INIT);
            gold_reg        <= GOLD_W'(GOLD_TOTAL);
            new_game_reg    <= 1'b0;
            respawn_reg     <= 1'b0;
            start_key_d_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            lives_reg       <= lives_next;
            gold_reg        <= gold_next;
            new_game_reg    <= new_game_next;
            respawn_reg     <= respawn_next;
            start_key_d_reg <= start_key;
        end
    end

    always_comb begin
        state_next    = state_reg;
        lives_next    = lives_reg;
        gold_next     = gold_reg;
        new_game_next = 1'b0;
        respawn_next  = 1'b0;
        case (state_reg)
            BLANK: begin
                if (startOfFrame) state_next = START;
            end
            START: begin
                if (key_rise) begin
                    state_next    = PLAY;
                    new_game_next = 1'b1;
                    lives_next    = LIVES_W'(LIVES_INIT);
                    gold_next     = GOLD_W'(GOLD_TOTAL);
                end
            end
            PLAY: begin
                // A hit wins over a same-cycle gold pulse: the death is shown, no win.
                if (player_hit) begin
                    if (lives_reg <= LIVES_W'(1)) begin
                        lives_next = '0;
                        state_next = GAME_OVER;
                    end else begin
                        lives_next = lives_reg - 1'b1;
                        state_next = DEATH;
                    end
                end else if (gold_collected) begin
                    if (gold_reg != '0) gold_next = gold_reg - 1'b1;
                    if (gold_reg == GOLD_W'(1)) state_next = WIN;
                end
            end
            DEATH: begin
                if (timer_done) begin
                    state_next   = PLAY;
                    respawn_next = 1'b1;
                end
            end
            WIN, GAME_OVER: begin
                if (key_rise || timer_done) state_next = START;
            end
            default: state_next = BLANK;
        endcase
    end

    // Any state change restarts the frame count, so each timed screen starts at zero.
    assign timer_clear    = (state_next != state_reg) ||
                            !(state_reg inside {DEATH, WIN, GAME_OVER});
    assign timer_terminal = (state_reg == DEATH) ? CNT_W'(DEATH_FRAMES - 1)
                                                 : CNT_W'(END_FRAMES - 1);

    frame_timer #(
        .CNT_W(CNT_W)
    ) u_frame_timer (
        .clk         (clk),
        .resetN      (resetN),
        .clear       (timer_clear),
        .startOfFrame(startOfFrame),
        .terminal    (timer_terminal),
        .done        (timer_done)
    );

    assign game_state = state_reg;
    assign lives      = lives_reg;
    assign gold_left  = gold_reg;
    assign new_game   = new_game_reg;
    assign respawn    = respawn_reg;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Scenario and randomized checks of game_state_ctrl against a frame-counting
// reference model of the game rules.
module tb_game_state_ctrl;

    localparam int LIVES_INIT   = 3;
    localparam int GOLD_TOTAL   = 8;
    localparam int DEATH_FRAMES = 60;
    localparam int END_FRAMES   = 180;
    localparam int SOF_PERIOD   = 4;
    localparam int DEATH_LIMIT  = DEATH_FRAMES * SOF_PERIOD + 20;
    localparam int END_LIMIT    = END_FRAMES * SOF_PERIOD + 20;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       startOfFrame = 1'b0;
    logic       start_key = 1'b0;
    logic       player_hit = 1'b0;
    logic       gold_collected = 1'b0;
    logic [2:0] game_state;
    logic [2:0] lives;
    logic [7:0] gold_left;
    logic       new_game;
    logic       respawn;

    int checks = 0;
    int errors = 0;

    // reference model: screen, lives, gold, frames elapsed on a timed screen
    int m_state = 0, m_lives = LIVES_INIT, m_gold = GOLD_TOTAL, m_frames = 0;
    bit m_ng = 0, m_rs = 0, m_key = 0;
    int sof_cnt = 0;

    always #5 clk = ~clk;

    game_state_ctrl #(
        .LIVES_INIT  (LIVES_INIT),
        .GOLD_TOTAL  (GOLD_TOTAL),
        .DEATH_FRAMES(DEATH_FRAMES),
        .END_FRAMES  (END_FRAMES)
    ) dut (
        .clk           (clk),
        .resetN        (resetN),
        .startOfFrame  (startOfFrame),
        .start_key     (start_key),
        .player_hit    (player_hit),
        .gold_collected(gold_collected),
        .game_state    (game_state),
        .lives         (lives),
        .gold_left     (gold_left),
        .new_game      (new_game),
        .respawn       (respawn)
    );

    always @(negedge clk) begin
        if (sof_cnt == SOF_PERIOD - 1) begin
            sof_cnt = 0;
            startOfFrame = 1'b1;
        end else begin
            sof_cnt++;
            startOfFrame = 1'b0;
        end
    end

    always @(posedge clk) begin
        bit rise;
        rise = start_key && !m_key;
        if (!resetN) begin
            m_state = 0; m_lives = LIVES_INIT; m_gold = GOLD_TOTAL;
            m_frames = 0; m_ng = 0; m_rs = 0; m_key = 0;
        end else begin
            m_key = start_key;
            m_ng = 0;
            m_rs = 0;
            case (m_state)
                0: if (startOfFrame) m_state = 1;
                1: if (rise) begin
                    m_state = 2; m_ng = 1; m_lives = LIVES_INIT;
                    m_gold = GOLD_TOTAL; m_frames = 0;
                end
                2: if (player_hit) begin
                    m_lives = m_lives - 1;
                    m_state = (m_lives == 0) ? 4 : 5;
                    m_frames = 0;
                end else if (gold_collected) begin
                    if (m_gold == 1) begin m_state = 3; m_frames = 0; end
                    if (m_gold > 0) m_gold = m_gold - 1;
                end
                5: if (startOfFrame) begin
                    m_frames++;
                    if (m_frames == DEATH_FRAMES) begin
                        m_state = 2; m_rs = 1; m_frames = 0;
                    end
                end
                3, 4: if (rise) begin
                    m_state = 1; m_frames = 0;
                end else if (startOfFrame) begin
                    m_frames++;
                    if (m_frames == END_FRAMES) begin m_state = 1; m_frames = 0; end
                end
                default: m_state = 0;
            endcase
        end
    end

    function automatic logic [15:0] exp_vec();
        return {m_state[2:0], m_lives[2:0], m_gold[7:0], m_ng, m_rs};
    endfunction

    function automatic logic [15:0] dut_vec();
        return {game_state, lives, gold_left, new_game, respawn};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        start_key = 1'b0;
        repeat (3) tick();
        checks++;
        if ({game_state, lives, gold_left, new_game, respawn} !== {3'd0, 3'd3, 8'd8, 2'b00}) begin
            errors++;
            $display("FAIL reset_values got=%h want=%h", dut_vec(), {3'd0, 3'd3, 8'd8, 2'b00});
        end
        resetN = 1'b1;
        $display("reset released: state=%0d lives=%0d gold=%0d", game_state, lives, gold_left);
    endtask

    task automatic test_start();
        int n = 0;
        while (game_state != 3'd1 && n < 2 * SOF_PERIOD + 4) begin
            tick(); n++;
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL start_wait got=%h want=%h", dut_vec(), exp_vec());
            end
        end
        checks++;
        if (game_state !== 3'd1) begin
            errors++; $display("FAIL blank_to_start got=%0d want=1", game_state);
        end
        start_key = 1'b1;
        tick();
        checks++;
        if ({game_state, new_game, lives, gold_left} !== {3'd2, 1'b1, 3'd3, 8'd8} ||
            dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL start_press got=%h want=%h", dut_vec(), exp_vec());
        end
        tick();
        checks++;
        if (new_game !== 1'b0 || dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL new_game_width got=%b want=0", new_game);
        end
        start_key = 1'b0;
        $display("start press: state=%0d lives=%0d gold=%0d", game_state, lives, gold_left);
    endtask

    task automatic test_win();
        int n = 0;
        for (int i = 0; i < GOLD_TOTAL; i++) begin
            gold_collected = 1'b1;
            tick();
            gold_collected = 1'b0;
            checks++;
            if (gold_left !== 8'(GOLD_TOTAL - 1 - i) ||
                game_state !== ((i == GOLD_TOTAL - 1) ? 3'd3 : 3'd2)) begin
                errors++;
                $display("FAIL gold_step%0d got state=%0d gold=%0d want gold=%0d",
                         i, game_state, gold_left, GOLD_TOTAL - 1 - i);
            end
            $display("gold pulse %0d: state=%0d gold_left=%0d", i, game_state, gold_left);
            repeat (4) tick();
        end
        while (game_state == 3'd3 && n < END_LIMIT) begin
            tick(); n++;
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL win_hold got=%h want=%h", dut_vec(), exp_vec());
            end
        end
        checks++;
        if (game_state !== 3'd1 || n < (END_FRAMES - 2) * SOF_PERIOD) begin
            errors++; $display("FAIL win_exit got state=%0d after %0d cycles want 1", game_state, n);
        end
        $display("win screen left after %0d cycles", n);
    endtask

    task automatic test_death();
        int n = 0;
        start_key = 1'b1;
        tick();
        start_key = 1'b0;
        player_hit = 1'b1;
        tick();
        player_hit = 1'b0;
        checks++;
        if (game_state !== 3'd5 || lives !== 3'd2) begin
            errors++; $display("FAIL hit_to_death got state=%0d lives=%0d want 5/2", game_state, lives);
        end
        $display("hit: state=%0d lives=%0d", game_state, lives);
        player_hit = 1'b1; gold_collected = 1'b1; start_key = 1'b1;
        tick();
        player_hit = 1'b0; gold_collected = 1'b0; start_key = 1'b0;
        checks++;
        if ({game_state, lives, gold_left} !== {3'd5, 3'd2, 8'd8}) begin
            errors++; $display("FAIL death_ignore got=%h want=%h", dut_vec(), exp_vec());
        end
        while (game_state != 3'd2 && n < DEATH_LIMIT) begin
            tick(); n++;
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL death_wait got=%h want=%h", dut_vec(), exp_vec());
            end
        end
        checks++;
        if (game_state !== 3'd2 || respawn !== 1'b1) begin
            errors++; $display("FAIL respawn got state=%0d respawn=%b want 2/1", game_state, respawn);
        end
        tick();
        checks++;
        if (respawn !== 1'b0) begin
            errors++; $display("FAIL respawn_width got=%b want=0", respawn);
        end
        $display("respawn after %0d cycles", n);
    endtask

    task automatic test_game_over();
        int n = 0;
        player_hit = 1'b1;
        tick();
        player_hit = 1'b0;
        while (game_state != 3'd2 && n < DEATH_LIMIT) begin
            tick(); n++;
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL go_death_wait got=%h want=%h", dut_vec(), exp_vec());
            end
        end
        player_hit = 1'b1;
        tick();
        player_hit = 1'b0;
        checks++;
        if (game_state !== 3'd4 || lives !== 3'd0) begin
            errors++; $display("FAIL last_hit got state=%0d lives=%0d want 4/0", game_state, lives);
        end
        $display("last hit: state=%0d lives=%0d", game_state, lives);
        repeat (5) tick();
        start_key = 1'b1;
        tick();
        checks++;
        if (game_state !== 3'd1 || new_game !== 1'b0) begin
            errors++; $display("FAIL early_exit got state=%0d new_game=%b want 1/0", game_state, new_game);
        end
        start_key = 1'b0;
        tick();
        start_key = 1'b1;
        tick();
        start_key = 1'b0;
        checks++;
        if ({game_state, lives, new_game} !== {3'd2, 3'd3, 1'b1}) begin
            errors++; $display("FAIL second_press got=%h want=%h", dut_vec(), exp_vec());
        end
        $display("second press: state=%0d lives=%0d", game_state, lives);
    endtask

    task automatic test_simultaneous();
        int n = 0;
        for (int i = 0; i < GOLD_TOTAL - 1; i++) begin
            gold_collected = 1'b1;
            tick();
            gold_collected = 1'b0;
            tick();
        end
        checks++;
        if (gold_left !== 8'd1 || game_state !== 3'd2) begin
            errors++; $display("FAIL gold_to_one got gold=%0d state=%0d want 1/2", gold_left, game_state);
        end
        player_hit = 1'b1; gold_collected = 1'b1;
        tick();
        player_hit = 1'b0; gold_collected = 1'b0;
        checks++;
        if ({game_state, lives, gold_left} !== {3'd5, 3'd2, 8'd1}) begin
            errors++; $display("FAIL hit_beats_gold got=%h want=%h", dut_vec(), exp_vec());
        end
        $display("hit+gold: state=%0d gold_left=%0d", game_state, gold_left);
        while (game_state != 3'd2 && n < DEATH_LIMIT) begin
            tick(); n++;
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL simul_death_wait got=%h want=%h", dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid_death();
        int n = 0;
        start_key = 1'b1;
        player_hit = 1'b1;
        tick();
        player_hit = 1'b0;
        while (!(m_state == 5 && m_frames == 30) && n < DEATH_LIMIT) begin
            tick(); n++;
        end
        checks++;
        if (game_state !== 3'd5) begin
            errors++; $display("FAIL mid_death_setup got state=%0d want 5", game_state);
        end
        resetN = 1'b0;
        tick();
        resetN = 1'b1;
        checks++;
        if ({game_state, lives, gold_left, new_game, respawn} !== {3'd0, 3'd3, 8'd8, 2'b00}) begin
            errors++; $display("FAIL mid_reset got=%h want=%h", dut_vec(), {3'd0, 3'd3, 8'd8, 2'b00});
        end
        $display("reset mid-death: state=%0d lives=%0d", game_state, lives);
        for (int i = 0; i < 30; i++) begin
            tick();
            checks++;
            if (new_game !== 1'b0 || game_state == 3'd2 || dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL held_key got=%h want=%h", dut_vec(), exp_vec());
            end
        end
        start_key = 1'b0;
        tick();
        start_key = 1'b1;
        tick();
        start_key = 1'b0;
        checks++;
        if (game_state !== 3'd2 || new_game !== 1'b1) begin
            errors++; $display("FAIL repress got state=%0d new_game=%b want 2/1", game_state, new_game);
        end
        player_hit = 1'b1;
        tick();
        player_hit = 1'b0;
        n = 0;
        while (game_state != 3'd2 && n < DEATH_LIMIT) begin
            tick(); n++;
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL fresh_death got=%h want=%h", dut_vec(), exp_vec());
            end
        end
        $display("fresh death lasted %0d cycles", n);
    endtask

    task automatic test_random();
        int mism = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) start_key = ~start_key;
            player_hit     = ($urandom_range(29) == 0);
            gold_collected = ($urandom_range(9) == 0);
            resetN         = ($urandom_range(799) != 0);
            tick();
            checks++;
            if (dut_vec() !== exp_vec() || (new_game && respawn)) begin
                errors++; mism++;
                if (mism < 10) $display("FAIL random_cycle%0d got=%h want=%h", i, dut_vec(), exp_vec());
            end
        end
        start_key = 1'b0; player_hit = 1'b0; gold_collected = 1'b0; resetN = 1'b1;
        $display("random run done: final state=%0d lives=%0d gold=%0d", game_state, lives, gold_left);
    endtask

    initial begin
        test_reset();
        test_start();
        test_win();
        test_death();
        test_game_over();
        test_simultaneous();
        test_reset_mid_death();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
